fpadd_arbiter: RTL
==================

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 Parameter: LAT, default 2, pipeline latency of the shared FP adder in cycles from fpu_start to valid fpu_result; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operand pair to add.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N's operands this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  IEEE 754 single-precision operands of requester N.
REQ-007 rsp0_valid / rsp1_valid  output  1  sum for requester N is available.
REQ-008 rsp0_ready / rsp1_ready  input  1  requester N takes the sum this cycle.
REQ-009 rsp0_data / rsp1_data  output  32  IEEE 754 sum returned to requester N.
REQ-010 fpu_a, fpu_b  output  32  operands driven to the shared adder.
REQ-011 fpu_start  output  1  one-cycle launch pulse to the shared adder.
REQ-012 fpu_result  input  32  adder sum, valid exactly LAT cycles after the fpu_start cycle.

Function
REQ-013 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESP.
REQ-014 In IDLE, reqN_ready SHALL be 1 only for the arbitration winner; it SHALL be 0 in all other states.
REQ-015 Arbitration SHALL work as follows: with one request valid, that requester wins; with both valid, the requester not granted last wins (round-robin).
REQ-016 On a handshake (valid & ready), the block SHALL latch the operands and the winner ID, update last_grant, and go to LAUNCH.
REQ-017 In LAUNCH, fpu_start SHALL be 1 for exactly one cycle; fpu_a/fpu_b SHALL hold the latched operands from LAUNCH through the end of WAIT; the next state SHALL be WAIT.
REQ-018 WAIT SHALL count LAT cycles; in the LAT-th cycle after LAUNCH, the block SHALL capture fpu_result into the response register and go to RESP.
REQ-019 In RESP, rspN_valid SHALL be 1 only for the latched winner; rspN_data SHALL hold the captured sum and stay stable until the handshake.
REQ-020 On the rspN handshake, the FSM SHALL return to IDLE, and a new request SHALL be acceptable in the next cycle.
REQ-021 Latency SHALL be LAT+2 cycles from the accept cycle to the first rsp_valid cycle, and the minimum issue interval SHALL be LAT+3 cycles.
REQ-022 rspN_data of the requester that is not selected SHALL be 0, and rsp_valid SHALL never be 1 for both requesters at once.
REQ-023 reqN_valid deasserting while the FSM is not in IDLE SHALL have no effect; a request is consumed only on handshake.
REQ-024 The arbiter SHALL NOT inspect or modify operand or result bits; IEEE handling belongs to the adder.

Reset
REQ-025 While rst is 1, the state SHALL be IDLE and the outputs SHALL be: req*_ready 0, rsp*_valid 0, rsp*_data 0, fpu_a 0, fpu_b 0, fpu_start 0, WAIT counter 0.
REQ-026 Reset SHALL set last_grant to requester 1, so that requester 0 wins the first simultaneous request.
REQ-027 A reset asserted mid-operation SHALL abandon the transaction; any fpu_result returned afterwards SHALL be ignored.

Configuration
REQ-028 When the macro FPADD_ARB_STATS_EN is defined, the block SHALL add outputs stat0_cnt and stat1_cnt (16 bits each), counting completed response handshakes per requester.
REQ-029 The stat counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-030 When FPADD_ARB_STATS_EN is undefined, the stat ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Single request, LAT=2, rsp0_ready=1: req0 accepted with a=32'h3F800000 and b=32'h40000000 at cycle 0 -> fpu_start at cycle 1; model returns 32'h40400000 at cycle 3; rsp0_valid=1 with rsp0_data=32'h40400000 at cycle 4; req0_ready=1 again at cycle 5.
REQ-032 Both requests held valid for 4 transactions -> grant order 0,1,0,1; rsp1_valid never 1 during req0's transaction.
REQ-033 Back-pressure: rsp1_ready=0 for 5 cycles in RESP -> rsp1_valid and rsp1_data stay stable; both req*_ready stay 0; no fpu_start.
REQ-034 rst pulsed during WAIT -> next cycle IDLE with all outputs 0; a late fpu_result is never returned; the first simultaneous request afterwards is granted to req0.
REQ-035 LAT=1 and LAT=7 builds -> accept-to-rsp_valid latency of 3 and 9 cycles respectively.
REQ-036 With FPADD_ARB_STATS_EN defined, forced counters at 16'hFFFE followed by 3 req0 completions -> stat0_cnt=16'hFFFF and stat1_cnt unchanged.

Source files
------------

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: two-requester round-robin front end for one shared,
// fixed-latency single-precision FP adder.
//
// One transaction is in flight at a time. The states are IDLE (arbitrate and
// accept), LAUNCH (one-cycle fpu_start pulse), WAIT (LAT cycles for the adder)
// and RESP (hold the sum until the winner takes it). Operand and result bits
// pass through untouched; all IEEE handling lives in the adder.
//
// Parameters
//   LAT          adder latency, fpu_start cycle to valid fpu_result (1..7)
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   reqN_valid   requester N offers an operand pair (reqN_a, reqN_b)
//   reqN_ready   requester N is accepted this cycle (IDLE winner only)
//   rspN_valid   sum for requester N is available on rspN_data
//   rspN_ready   requester N takes the sum this cycle
//   rspN_data    sum for requester N; 0 while N is not the responder
//   fpu_a/fpu_b  operands to the shared adder
//   fpu_start    one-cycle launch pulse to the shared adder
//   fpu_result   adder sum, valid exactly LAT cycles after fpu_start
//   stat0_cnt,   saturating counts of completed response handshakes per
//   stat1_cnt    requester; present only with FPADD_ARB_STATS_EN defined
//
// Build option
//   FPADD_ARB_STATS_EN  adds the stat0_cnt/stat1_cnt outputs and counters.

module fpadd_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,

  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_start,
`ifdef FPADD_ARB_STATS_EN
  output logic [15:0] stat0_cnt,
  output logic [15:0] stat1_cnt,
`endif
  input  logic [31:0] fpu_result
);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } state_e;

  localparam logic [2:0] LatCnt = 3'(LAT);

  state_e      state_q;
  logic        last_grant_q;  // requester granted most recently
  logic        winner_q;      // requester owning the transaction in flight
  logic [2:0]  wait_cnt_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        fpu_start_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [31:0] rsp0_data_q;
  logic [31:0] rsp1_data_q;

  logic        arb_win;
  logic        idle_ok;
  logic        accept;
  logic        rsp_hs;

  // Round-robin: a lone request wins outright; on a tie the requester not
  // granted last time wins.
  always_comb begin
    arb_win = 1'b0;
    if (req0_valid && req1_valid) begin
      arb_win = ~last_grant_q;
    end else begin
      arb_win = req1_valid;
    end
  end

  // Ready is combinational so an IDLE request is accepted in the same cycle;
  // it is masked during reset so no handshake can appear while rst is high.
  assign idle_ok    = (state_q == StIdle) && !rst;
  assign req0_ready = idle_ok && req0_valid && !arb_win;
  assign req1_ready = idle_ok && req1_valid && arb_win;

  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      winner_q     <= 1'b0;
      wait_cnt_q   <= 3'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      fpu_start_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= 32'd0;
      rsp1_data_q  <= 32'd0;
    end else begin
      fpu_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            winner_q     <= arb_win;
            last_grant_q <= arb_win;
            op_a_q       <= arb_win ? req1_a : req0_a;
            op_b_q       <= arb_win ? req1_b : req0_b;
            fpu_start_q  <= 1'b1;  // high for the whole LAUNCH cycle
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          // The first WAIT cycle is cycle 1 after LAUNCH.
          wait_cnt_q <= 3'd1;
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q == LatCnt) begin
            wait_cnt_q   <= 3'd0;
            rsp0_valid_q <= ~winner_q;
            rsp1_valid_q <= winner_q;
            rsp0_data_q  <= winner_q ? 32'd0 : fpu_result;
            rsp1_data_q  <= winner_q ? fpu_result : 32'd0;
            state_q      <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        StResp: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 32'd0;
            rsp1_data_q  <= 32'd0;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Operands stay on the adder inputs from LAUNCH until the next accept.
  assign fpu_a      = op_a_q;
  assign fpu_b      = op_b_q;
  assign fpu_start  = fpu_start_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

`ifdef FPADD_ARB_STATS_EN
  logic [15:0] stat0_q;
  logic [15:0] stat1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat0_q <= 16'd0;
      stat1_q <= 16'd0;
    end else begin
      if (rsp0_valid_q && rsp0_ready && (stat0_q != 16'hFFFF)) begin
        stat0_q <= stat0_q + 16'd1;
      end
      if (rsp1_valid_q && rsp1_ready && (stat1_q != 16'hFFFF)) begin
        stat1_q <= stat1_q + 16'd1;
      end
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`endif

endmodule
